// File: rtl/ucsbece154b_gshare_predictor_pkg.sv
// Shared types for the gshare branch predictor: PHT counter encodings,
// the PHT reset value, the BTB payload and the saturating counter update.
package ucsbece154b_gshare_predictor_pkg;

  localparam int unsigned XLEN = 32;

  // 2-bit saturating direction counter; bit 1 is the taken prediction
  typedef enum logic [1:0] {
    pht_snt = 2'b00,
    pht_wnt = 2'b01,
    pht_wt  = 2'b10,
    pht_st  = 2'b11
  } pht_ctr_e;

  localparam pht_ctr_e PHT_RESET = pht_wnt;

  // Data carried by a BTB entry alongside its tag
  typedef struct packed {
    logic            jump;
    logic [XLEN-1:0] target;
  } btb_payload_t;

  // Move one step toward the observed outcome, saturating at both ends
  function automatic pht_ctr_e pht_train(input pht_ctr_e ctr, input logic taken);
    pht_ctr_e nxt;
    nxt = ctr;
    case (ctr)
      pht_snt: nxt = taken ? pht_wnt : pht_snt;
      pht_wnt: nxt = taken ? pht_wt  : pht_snt;
      pht_wt:  nxt = taken ? pht_st  : pht_wnt;
      pht_st:  nxt = taken ? pht_st  : pht_wt;
      default: nxt = ctr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ucsbece154b_gshare_predictor_btb.sv
// Tagged direct-mapped branch target buffer: combinational read, write on
// the rising clock edge. Only the valid bits are reset.
// Ports:
//   clk, reset_i          clock / asynchronous active-low reset
//   lookup_pc             fetch PC to look up
//   hit                   entry valid and tag matches lookup_pc
//   lookup_data           jump flag and target of the indexed entry
//   wr_en, wr_pc, wr_data allocate/overwrite the entry indexed by wr_pc
module ucsbece154b_gshare_predictor_btb
  import ucsbece154b_gshare_predictor_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 32
) (
  input  logic            clk,
  input  logic            reset_i,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            hit,
  output btb_payload_t    lookup_data,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  btb_payload_t    wr_data
);

  localparam int unsigned IDX   = $clog2(NUM_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  logic [NUM_ENTRIES-1:0] valid;
  logic [TAG_W-1:0]       tags [NUM_ENTRIES];
  btb_payload_t           data [NUM_ENTRIES];

  logic [IDX-1:0]   rd_idx;
  logic [IDX-1:0]   wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;

  // Instructions are word aligned, so the low two PC bits carry no information
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], wr_pc[1:0]};

  assign rd_idx = lookup_pc[IDX+1:2];
  assign rd_tag = lookup_pc[XLEN-1:IDX+2];
  assign wr_idx = wr_pc[IDX+1:2];
  assign wr_tag = wr_pc[XLEN-1:IDX+2];

  assign hit         = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign lookup_data = data[rd_idx];

  // Valid bits: cleared by reset, set on allocation, never invalidated
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and payload storage is not reset; valid gates its use
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/ucsbece154b_gshare_predictor.sv
// Gshare branch predictor. Fetch-side lookup returns a same-cycle prediction
// from the BTB and a PHT indexed by PC xor GHR; execute-side updates train the
// BTB and PHT and repair the speculative GHR on mispredictions.
// Ports:
//   clk, reset_i                      clock / asynchronous active-low reset
//   pc_i, ghr_shift_i                 fetch PC; shift GHR with this prediction
//   predict_taken_o, predict_target_o fetch-stage prediction
//   pht_index_o, ghr_snapshot_o       lookup context carried down the pipe
//   upd_*                             execute-stage resolution and its context
module ucsbece154b_gshare_predictor
  import ucsbece154b_gshare_predictor_pkg::*;
#(
  parameter int unsigned NUM_BTB_ENTRIES = 32,
  parameter int unsigned NUM_GHR_BITS    = 5
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic [XLEN-1:0]         pc_i,
  input  logic                    ghr_shift_i,
  output logic                    predict_taken_o,
  output logic [XLEN-1:0]         predict_target_o,
  output logic [NUM_GHR_BITS-1:0] pht_index_o,
  output logic [NUM_GHR_BITS-1:0] ghr_snapshot_o,
  input  logic                    upd_valid_i,
  input  logic [XLEN-1:0]         upd_pc_i,
  input  logic                    upd_is_branch_i,
  input  logic                    upd_is_jump_i,
  input  logic                    upd_taken_i,
  input  logic [XLEN-1:0]         upd_target_i,
  input  logic [NUM_GHR_BITS-1:0] upd_pht_index_i,
  input  logic [NUM_GHR_BITS-1:0] upd_ghr_i,
  input  logic                    upd_mispredict_i
);

  localparam int unsigned G           = NUM_GHR_BITS;
  localparam int unsigned PHT_ENTRIES = 1 << G;

  logic [G-1:0] ghr;
  logic [G-1:0] ghr_next;
  pht_ctr_e     pht [PHT_ENTRIES];

  logic         btb_hit;
  btb_payload_t btb_rd;
  logic         btb_wr_en;
  btb_payload_t btb_wr;

  // Allocate on every jump and every taken branch; not-taken branches leave the BTB alone
  assign btb_wr_en     = upd_valid_i && (upd_is_jump_i || (upd_is_branch_i && upd_taken_i));
  assign btb_wr.jump   = upd_is_jump_i;
  assign btb_wr.target = upd_target_i;

  ucsbece154b_gshare_predictor_btb #(
    .NUM_ENTRIES (NUM_BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .reset_i     (reset_i),
    .lookup_pc   (pc_i),
    .hit         (btb_hit),
    .lookup_data (btb_rd),
    .wr_en       (btb_wr_en),
    .wr_pc       (upd_pc_i),
    .wr_data     (btb_wr)
  );

  // Same-cycle lookup; reset forces not-taken even before the arrays settle
  assign pht_index_o      = pc_i[G+1:2] ^ ghr;
  assign ghr_snapshot_o   = ghr;
  assign predict_taken_o  = reset_i && btb_hit && (btb_rd.jump || pht[pht_index_o][1]);
  assign predict_target_o = btb_rd.target;

  // A repair flushes the fetched instruction, so it overrides the speculative shift
  always_comb begin
    ghr_next = ghr;
    if (upd_valid_i && upd_mispredict_i && upd_is_branch_i) begin
      ghr_next = {upd_ghr_i[G-2:0], upd_taken_i};
    end else if (upd_valid_i && upd_mispredict_i && upd_is_jump_i) begin
      ghr_next = upd_ghr_i;
    end else if (ghr_shift_i) begin
      ghr_next = {ghr[G-2:0], predict_taken_o};
    end
  end

  // Global history register
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      ghr <= '0;
    end else begin
      ghr <= ghr_next;
    end
  end

  // Pattern history table, trained only by conditional branches
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < int'(PHT_ENTRIES); i++) begin
        pht[i] <= PHT_RESET;
      end
    end else if (upd_valid_i && upd_is_branch_i) begin
      pht[upd_pht_index_i] <= pht_train(pht[upd_pht_index_i], upd_taken_i);
    end
  end

endmodule
